// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, I-memory read handshake, and a
// direct-mapped BTB with 2-bit saturating counters feeding IF/ID.
module if_fetch_stage #(
    parameter int unsigned WORD_SIZE    = 16,
    parameter int unsigned BTB_IDX_BITS = 8,
    parameter logic [WORD_SIZE-1:0] RESET_PC = '0,
    parameter logic [3:0] OPCODE_NOP = 4'hF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 stall,
    input  logic                 redirect,
    input  logic [WORD_SIZE-1:0] redirect_pc,
    input  logic                 update_valid,
    input  logic [WORD_SIZE-1:0] update_pc,
    input  logic [WORD_SIZE-1:0] update_target,
    input  logic                 update_taken,
    output logic                 i_readM,
    output logic [WORD_SIZE-1:0] i_address,
    input  logic [WORD_SIZE-1:0] i_data,
    input  logic                 i_ready,
    output logic [WORD_SIZE-1:0] pc_IF,
    output logic [WORD_SIZE-1:0] instruction_IF,
    output logic [WORD_SIZE-1:0] branch_predicted_pc_IF,
    output logic                 tag_match_IF,
    output logic                 if_stall
);

    localparam int unsigned TAG_BITS = WORD_SIZE - BTB_IDX_BITS;
    localparam int unsigned ENTRIES  = 1 << BTB_IDX_BITS;
    localparam logic [WORD_SIZE-1:0] NOP = {OPCODE_NOP, {(WORD_SIZE - 4){1'b0}}};

    typedef enum logic [0:0] {StReq, StHold} state_t;

    state_t               state;
    logic [WORD_SIZE-1:0] pc;
    logic [WORD_SIZE-1:0] inst_buf;

    logic [ENTRIES-1:0]   btb_valid;
    logic [TAG_BITS-1:0]  btb_tag    [ENTRIES];
    logic [WORD_SIZE-1:0] btb_target [ENTRIES];
    logic [1:0]           btb_cnt    [ENTRIES];

    logic [BTB_IDX_BITS-1:0] idx;
    logic [TAG_BITS-1:0]     pc_tag;
    logic                    hit;
    logic [WORD_SIZE-1:0]    pred_pc;

    logic [BTB_IDX_BITS-1:0] u_idx;
    logic [TAG_BITS-1:0]     u_tag;
    logic                    u_hit;

    // Lookup reads pre-edge BTB contents, so a same-cycle update is seen next cycle.
    always_comb begin
        idx     = pc[BTB_IDX_BITS-1:0];
        pc_tag  = pc[WORD_SIZE-1:BTB_IDX_BITS];
        hit     = btb_valid[idx] && (btb_tag[idx] == pc_tag);
        pred_pc = (hit && btb_cnt[idx][1]) ? btb_target[idx] : pc + WORD_SIZE'(1);
        u_idx   = update_pc[BTB_IDX_BITS-1:0];
        u_tag   = update_pc[WORD_SIZE-1:BTB_IDX_BITS];
        u_hit   = btb_valid[u_idx] && (btb_tag[u_idx] == u_tag);
    end

    always_comb begin
        pc_IF                  = pc;
        i_address              = pc;
        tag_match_IF           = hit;
        branch_predicted_pc_IF = pred_pc;
        if (state == StReq) begin
            i_readM        = 1'b1;
            if_stall       = ~i_ready;
            instruction_IF = i_ready ? i_data : NOP;
        end else begin
            i_readM        = 1'b0;
            if_stall       = 1'b0;
            instruction_IF = inst_buf;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc       <= RESET_PC;
            state    <= StReq;
            inst_buf <= NOP;
        end else begin
            case (state)
                StReq: begin
                    if (redirect) begin
                        pc <= redirect_pc;
                    end else if (i_ready) begin
                        if (stall) begin
                            inst_buf <= i_data;
                            state    <= StHold;
                        end else begin
                            pc <= pred_pc;
                        end
                    end
                end
                StHold: begin
                    if (redirect) begin
                        pc    <= redirect_pc;
                        state <= StReq;
                    end else if (!stall) begin
                        pc    <= pred_pc;
                        state <= StReq;
                    end
                end
                default: state <= StReq;
            endcase
        end
    end

    // Only valid bits need reset; tag/target/cnt are qualified by valid.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            btb_valid <= '0;
        end else if (update_valid) begin
            if (u_hit) begin
                if (update_taken) begin
                    btb_cnt[u_idx]    <= (btb_cnt[u_idx] == 2'b11) ? 2'b11 : btb_cnt[u_idx] + 2'b01;
                    btb_target[u_idx] <= update_target;
                end else begin
                    btb_cnt[u_idx]    <= (btb_cnt[u_idx] == 2'b00) ? 2'b00 : btb_cnt[u_idx] - 2'b01;
                end
            end else if (update_taken) begin
                btb_valid[u_idx]  <= 1'b1;
                btb_tag[u_idx]    <= u_tag;
                btb_target[u_idx] <= update_target;
                btb_cnt[u_idx]    <= 2'b10;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: fetch sequencing, memory wait, IF/ID stall
// hold, BTB allocate/train, PC wrap, redirect priority and reset.
module tb_if_fetch_stage;

    localparam logic [15:0] NOP = 16'hF000;

    logic        clk = 1'b0;
    logic        reset_n, stall, redirect, update_valid, update_taken, i_ready;
    logic [15:0] redirect_pc, update_pc, update_target, i_data;
    logic        i_readM, tag_match_IF, if_stall;
    logic [15:0] i_address, pc_IF, instruction_IF, branch_predicted_pc_IF;

    int n_checks = 0;
    int n_fails  = 0;

    if_fetch_stage #(
        .WORD_SIZE(16), .BTB_IDX_BITS(8), .RESET_PC(16'h0000), .OPCODE_NOP(4'hF)
    ) dut (
        .clk(clk), .reset_n(reset_n), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .update_valid(update_valid), .update_pc(update_pc),
        .update_target(update_target), .update_taken(update_taken), .i_readM(i_readM),
        .i_address(i_address), .i_data(i_data), .i_ready(i_ready), .pc_IF(pc_IF),
        .instruction_IF(instruction_IF), .branch_predicted_pc_IF(branch_predicted_pc_IF),
        .tag_match_IF(tag_match_IF), .if_stall(if_stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic fetch(input string tag, input logic [15:0] pc, input logic [15:0] pred,
                         input logic tm);
        check({tag, " pc_IF"}, pc_IF, pc);
        check({tag, " i_address"}, i_address, pc);
        check({tag, " pred"}, branch_predicted_pc_IF, pred);
        check({tag, " tag_match"}, {15'b0, tag_match_IF}, {15'b0, tm});
    endtask

    task automatic flags(input string tag, input logic rd, input logic st, input logic [15:0] ins);
        check({tag, " i_readM"}, {15'b0, i_readM}, {15'b0, rd});
        check({tag, " if_stall"}, {15'b0, if_stall}, {15'b0, st});
        check({tag, " instr"}, instruction_IF, ins);
    endtask

    // Inputs change at a negedge; outputs are checked 1 time unit later.
    task automatic next;
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        update_valid = 1'b0; update_pc = '0; update_target = '0; update_taken = 1'b0;
        i_ready = 1'b1; i_data = 16'h1000;
        next; next;

        // Reset state with memory not ready
        reset_n = 1'b1; i_ready = 1'b0; #1;
        fetch("rst", 16'h0000, 16'h0001, 1'b0); flags("rst", 1'b1, 1'b1, NOP);
        next;

        // Sequential fetch
        i_ready = 1'b1; #1;
        fetch("seq0", 16'h0000, 16'h0001, 1'b0); flags("seq0", 1'b1, 1'b0, 16'h1000);
        next; #1; fetch("seq1", 16'h0001, 16'h0002, 1'b0);
        next; #1; fetch("seq2", 16'h0002, 16'h0003, 1'b0);
        next;

        // Memory wait at pc 3 for three cycles
        i_ready = 1'b0; #1;
        fetch("wait0", 16'h0003, 16'h0004, 1'b0); flags("wait0", 1'b1, 1'b1, NOP);
        next; #1; check("wait1 pc", pc_IF, 16'h0003); flags("wait1", 1'b1, 1'b1, NOP);
        next; #1; check("wait2 pc", pc_IF, 16'h0003); flags("wait2", 1'b1, 1'b1, NOP);
        next;
        i_ready = 1'b1; i_data = 16'hABCD; #1;
        check("wait done pc", pc_IF, 16'h0003); flags("wait done", 1'b1, 1'b0, 16'hABCD);
        next;

        // Allocate BTB entry for 0x0005 -> 0x0020 while fetching 0x0004
        update_valid = 1'b1; update_pc = 16'h0005; update_target = 16'h0020; update_taken = 1'b1;
        #1; fetch("alloc", 16'h0004, 16'h0005, 1'b0);
        next;
        update_valid = 1'b0; #1;
        fetch("hit5", 16'h0005, 16'h0020, 1'b1);
        next;
        // Redirect back to 0x0005 with a not-taken update (cnt 10 -> 01)
        redirect = 1'b1; redirect_pc = 16'h0005;
        update_valid = 1'b1; update_taken = 1'b0; #1;
        fetch("tgt", 16'h0020, 16'h0021, 1'b0);
        next;
        // cnt 01: weak not-taken; second not-taken update (-> 00) not seen this cycle
        redirect = 1'b0; #1;
        fetch("cnt01", 16'h0005, 16'h0006, 1'b1);
        next;
        update_valid = 1'b0; redirect = 1'b1; #1;
        fetch("pc6a", 16'h0006, 16'h0007, 1'b0);
        next;
        // cnt 00, taken update -> 01
        redirect = 1'b0; update_valid = 1'b1; update_taken = 1'b1; #1;
        fetch("cnt00", 16'h0005, 16'h0006, 1'b1);
        next;
        update_valid = 1'b0; redirect = 1'b1; #1;
        check("pc6b pc", pc_IF, 16'h0006);
        next;

        // cnt 01 still predicts fall-through; stall IF/ID on this fetch
        redirect = 1'b0; stall = 1'b1; i_data = 16'h1234; #1;
        fetch("cnt01b", 16'h0005, 16'h0006, 1'b1); flags("cap", 1'b1, 1'b0, 16'h1234);
        next;
        i_data = 16'h5555; #1;
        check("hold0 pc", pc_IF, 16'h0005); flags("hold0", 1'b0, 1'b0, 16'h1234);
        next;
        stall = 1'b0; #1;
        check("hold1 pc", pc_IF, 16'h0005); flags("hold1", 1'b0, 1'b0, 16'h1234);
        next;
        redirect = 1'b1; redirect_pc = 16'hFFFF; #1;
        check("release pc", pc_IF, 16'h0006); flags("release", 1'b1, 1'b0, 16'h5555);
        next;

        // PC wrap
        redirect = 1'b0; #1;
        fetch("wrap", 16'hFFFF, 16'h0000, 1'b0);
        next;
        stall = 1'b1; #1;
        check("wrapped pc", pc_IF, 16'h0000);
        next;

        // Redirect beats stall in HOLD
        redirect = 1'b1; redirect_pc = 16'h0040; #1;
        check("hold2 pc", pc_IF, 16'h0000); flags("hold2", 1'b0, 1'b0, 16'h5555);
        next;
        redirect = 1'b0; stall = 1'b1;
        update_valid = 1'b1; update_pc = 16'h0000; update_target = 16'h0030; update_taken = 1'b1;
        #1; check("redir pc", pc_IF, 16'h0040); check("redir i_readM", {15'b0, i_readM}, 16'h0001);
        next;

        // Reset mid-HOLD and mid-update
        reset_n = 1'b0; update_pc = 16'h0001; #1;
        check("hold3 i_readM", {15'b0, i_readM}, 16'h0000);
        next;
        reset_n = 1'b1; stall = 1'b0; update_valid = 1'b0; #1;
        fetch("rst2", 16'h0000, 16'h0001, 1'b0); flags("rst2", 1'b1, 1'b0, 16'h5555);
        next;
        redirect = 1'b1; redirect_pc = 16'h0005; #1;
        fetch("rst2 pc1", 16'h0001, 16'h0002, 1'b0);
        next;
        redirect = 1'b0; #1;
        fetch("rst2 pc5", 16'h0005, 16'h0006, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
